pixel_stream_out: RTL and testbench
===================================

Name: pixel_stream_out

Overview:
- Output stage directly downstream of the convolution/image-control path.
- Accepts the filtered pixel stream `pixel_i`/`pixel_valid_i`. That stream has no backpressure, so the block buffers it in a synchronous FIFO.
- Re-emits the pixels as a valid/ready stream with line and frame markers, derived from output-side column/row counters.
- Reports almost-full so upstream control can pause the pixel feed, and flags overflow if pixels are lost.

Parameters:
- DATA_W, 8, pixel width in bits.
- OUT_WIDTH, 638, filtered pixels per output line (RESOLUTION-KERNEL_W+1 for the 640-wide default).
- OUT_HEIGHT, 478, lines per output frame.
- FIFO_DEPTH, 16, buffer entries; must be a power of 2 and at least 4.
- AF_LEVEL, 12, fill level at or above which almost_full_o is asserted.

Ports:
- clk_i  in  1  system clock.
- srst_i  in  1  reset, synchronous, active-high.
- pixel_i  in  DATA_W  filtered pixel from the conv stage.
- pixel_valid_i  in  1  pixel_i is valid this cycle.
- data_o  out  DATA_W  output pixel.
- valid_o  out  1  data_o and the marker outputs are valid.
- ready_i  in  1  downstream accepts the beat.
- sol_o  out  1  beat is column 0 of a line.
- eol_o  out  1  beat is column OUT_WIDTH-1.
- sof_o  out  1  beat is column 0 of row 0.
- eof_o  out  1  beat is the last column of row OUT_HEIGHT-1.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO fill level.
- almost_full_o  out  1  level_o >= AF_LEVEL.
- overflow_o  out  1  sticky: a pixel was dropped.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset srst_i is synchronous and active-high.
- Reset values: all outputs 0, FIFO empty, col=0, row=0, overflow_o=0.
- Reset mid-stream: any data held in the FIFO is discarded. Counters restart at col=0, row=0.
- Write rule: a write occurs when pixel_valid_i=1 and either (level<FIFO_DEPTH) or (a read happens in the same cycle).
- Read rule: a read occurs when valid_o=1 and ready_i=1.
- FIFO style: show-ahead. valid_o = (level!=0).
  - data_o is the head entry, driven from a register or the RAM read port so it is stable while valid_o=1 and ready_i=0.
  - Latency from a write into an empty FIFO to valid_o=1 is 1 cycle.
- Stream stability: while valid_o=1 and ready_i=0, data_o and all markers hold stable. valid_o never drops without a read.
- Level update: level_o becomes level + wr - rd on the next cycle.
  - Simultaneous read and write when full: both happen, level stays FIFO_DEPTH.
  - Simultaneous read and write when empty: the write is stored, and valid_o rises the next cycle. There is no bypass; a read cannot occur while empty.
- Overflow: pixel_valid_i=1 with level==FIFO_DEPTH and no read means the pixel is dropped and overflow_o is set. It stays set until srst_i.
- Almost-full: almost_full_o is combinational from the level register, so it updates the cycle after the level changes.
- Counters col and row:
  - Advance only on a read.
  - col wraps from OUT_WIDTH-1 to 0, and then row increments.
  - row wraps from OUT_HEIGHT-1 to 0 after the eof beat.
- Markers, combinational from the counters and qualified by valid_o:
  - sol_o = (col==0)
  - eol_o = (col==OUT_WIDTH-1)
  - sof_o = (col==0 && row==0)
  - eof_o = eol_o && (row==OUT_HEIGHT-1)
- Marker overlap: when OUT_WIDTH=1, sol and eol assert on the same beat.
- Dropped pixels and markers: dropped pixels do not advance the counters. Markers therefore reflect accepted output beats only, and overflow_o tells the consumer the frame is corrupt.
- Pointers: write and read pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Shared package image_proc_pkg:
  - DATA_W default constant.
  - typedef logic [DATA_W-1:0] pixel_t.
  - Default OUT_WIDTH/OUT_HEIGHT constants derived from RESOLUTION and KERNEL_W.
- Sub-module pix_sync_fifo: parameters DATA_W and DEPTH; ports wr/rd/data/level/full/empty, show-ahead.
- pixel_stream_out keeps the counters, markers, almost-full and overflow logic.

Test Plan:
- Reset, then 3 writes (0x10, 0x11, 0x12) with ready_i=1 → valid_o rises 1 cycle after the first write; data_o shows 0x10, 0x11, 0x12 in order; the first beat has sol_o=1 and sof_o=1; level_o returns to 0.
- ready_i=0 while writing 16 pixels → level_o=16, almost_full_o=1 from level 12. A 17th pixel sets overflow_o=1, and the subsequent drain outputs exactly the first 16 values.
- Full FIFO with ready_i=1 and pixel_valid_i=1 in the same cycle → level_o stays 16, overflow_o stays 0, and the new pixel appears last.
- OUT_WIDTH=4, OUT_HEIGHT=2, 8 beats with random ready_i → eol_o on beats 3 and 7; sol_o on beats 0 and 4; eof_o only on beat 7; beat 8 has sof_o=1 again.
- Backpressure hold: ready_i=0 for 5 cycles with valid_o=1 → data_o, sol_o and eol_o stay constant across all 5 cycles.
- srst_i asserted with level_o=6 and col=2 → the next cycle valid_o=0, level_o=0 and overflow_o=0; the next accepted beat has sof_o=1.

Source files
------------

// File: rtl/image_proc_pkg.sv
// Shared constants and types for the image processing output path.
// Output geometry defaults follow from a valid-only convolution of a
// RESOLUTION x FRAME_LINES image with a KERNEL_W x KERNEL_W kernel.
package image_proc_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int RESOLUTION     = 640;
  localparam int FRAME_LINES    = 480;
  localparam int KERNEL_W       = 3;
  localparam int DEF_OUT_WIDTH  = RESOLUTION - KERNEL_W + 1;
  localparam int DEF_OUT_HEIGHT = FRAME_LINES - KERNEL_W + 1;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_AF_LEVEL   = 12;

  typedef logic [DEF_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/pix_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on rdata_o,
// and a read simply advances past it. Write and read requests are qualified
// internally so the pointers stay consistent even if a caller over-asks.
module pix_sync_fifo
  import image_proc_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_FIFO_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              wrEn;
  logic              rdEn;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rdEn    = rd_i && !empty_o;
  assign wrEn    = wr_i && (!full_o || rdEn);
  assign rdata_o = mem_q[rdPtr_q];
  assign level_o = level_q;

  // Next pointers and fill level; pointers wrap naturally at DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (wrEn) wrPtr_d = wrPtr_q + 1'b1;
    if (rdEn) rdPtr_d = rdPtr_q + 1'b1;
    case ({wrEn, rdEn})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers; reset empties the FIFO by clearing them.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_stream_out.sv
// Output stage of the image path: buffers the non-backpressured filtered
// pixel feed and re-emits it as a valid/ready stream with line and frame
// markers derived from output-side column/row counters. Pixels arriving at
// a full FIFO with no read are dropped and latch a sticky overflow flag.
module pixel_stream_out
  import image_proc_pkg::*;
#(
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int  OUT_HEIGHT = DEF_OUT_HEIGHT,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int  AF_LEVEL   = DEF_AF_LEVEL,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              pixel_valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sol_o,
  output logic              eol_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              almost_full_o,
  output logic              overflow_o
);

  localparam int COL_W = $clog2(OUT_WIDTH + 1);
  localparam int ROW_W = $clog2(OUT_HEIGHT + 1);

  logic [DATA_W-1:0] headData;
  logic [LVL_W-1:0]  level;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              wrEn;
  logic              rdEn;
  logic              lastCol;
  logic              lastRow;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              overflow_q, overflow_d;

  assign valid_o = !fifoEmpty;
  assign rdEn    = valid_o && ready_i;
  assign wrEn    = pixel_valid_i && (!fifoFull || rdEn);

  pix_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .wr_i    (wrEn),
    .wdata_i (pixel_i),
    .rd_i    (rdEn),
    .rdata_o (headData),
    .level_o (level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign lastCol = (col_q == COL_W'(OUT_WIDTH - 1));
  assign lastRow = (row_q == ROW_W'(OUT_HEIGHT - 1));

  // data_o is forced to zero when idle so the stream is quiet out of reset.
  assign data_o        = valid_o ? headData : '0;
  assign sol_o         = valid_o && (col_q == '0);
  assign eol_o         = valid_o && lastCol;
  assign sof_o         = valid_o && (col_q == '0) && (row_q == '0);
  assign eof_o         = valid_o && lastCol && lastRow;
  assign level_o       = level;
  assign almost_full_o = (level >= LVL_W'(AF_LEVEL));
  assign overflow_o    = overflow_q;

  // Counters advance only on accepted beats; overflow latches any dropped pixel.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    overflow_d = overflow_q;
    if (rdEn) begin
      if (lastCol) begin
        col_d = '0;
        row_d = lastRow ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (pixel_valid_i && fifoFull && !rdEn) overflow_d = 1'b1;
  end

  // Counter and overflow registers, restarted by reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pixel_stream_out.sv
// Directed bench for pixel_stream_out with a small 4x2 output frame so line
// and frame markers can be exercised in a handful of beats.
module tb_pixel_stream_out;

  localparam int DATA_W     = 8;
  localparam int OUT_WIDTH  = 4;
  localparam int OUT_HEIGHT = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int AF_LEVEL   = 12;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              srst_i = 1'b1;
  logic [DATA_W-1:0] pixel_i = '0;
  logic              pixel_valid_i = 1'b0;
  logic              ready_i = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              sol_o;
  logic              eol_o;
  logic              sof_o;
  logic              eof_o;
  logic [LVL_W-1:0]  level_o;
  logic              almost_full_o;
  logic              overflow_o;

  int vectors = 0;
  int miscompares = 0;
  int beats = 0;
  int got = 0;
  logic rdy;

  pixel_stream_out #(
    .DATA_W     (DATA_W),
    .OUT_WIDTH  (OUT_WIDTH),
    .OUT_HEIGHT (OUT_HEIGHT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AF_LEVEL   (AF_LEVEL)
  ) dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .pixel_i       (pixel_i),
    .pixel_valid_i (pixel_valid_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .sol_o         (sol_o),
    .eol_o         (eol_o),
    .sof_o         (sof_o),
    .eof_o         (eof_o),
    .level_o       (level_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o)
  );

  // Free-running 10-unit clock.
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one cycle of inputs and let the clock edge consume them.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] p, input logic r);
    pixel_valid_i = v;
    pixel_i       = p;
    ready_i       = r;
    tick();
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the head beat against beat index b of the 4x2 frame geometry.
  task automatic checkBeat(input string tag, input int b, input logic [DATA_W-1:0] expData);
    int c;
    int r;
    c = b % OUT_WIDTH;
    r = (b / OUT_WIDTH) % OUT_HEIGHT;
    checkOutput({tag, "_valid"}, valid_o, 1);
    checkOutput({tag, "_data"}, data_o, expData);
    checkOutput({tag, "_sol"}, sol_o, (c == 0));
    checkOutput({tag, "_eol"}, eol_o, (c == OUT_WIDTH - 1));
    checkOutput({tag, "_sof"}, sof_o, (c == 0 && r == 0));
    checkOutput({tag, "_eof"}, eof_o, (c == OUT_WIDTH - 1 && r == OUT_HEIGHT - 1));
  endtask

  // Linear sequence of directed steps.
  initial begin
    // Reset state
    srst_i = 1'b1;
    tick();
    tick();
    srst_i = 1'b0;
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_level", level_o, 0);
    checkOutput("rst_af", almost_full_o, 0);
    checkOutput("rst_ovf", overflow_o, 0);
    checkOutput("rst_sol", sol_o, 0);
    checkOutput("rst_sof", sof_o, 0);

    // Three pixels with ready held high
    applyStimulus(1'b1, 8'h10, 1'b1);
    checkOutput("t1_level0", level_o, 1);
    checkBeat("t1_b0", 0, 8'h10);
    applyStimulus(1'b1, 8'h11, 1'b1);
    checkOutput("t1_level1", level_o, 1);
    checkBeat("t1_b1", 1, 8'h11);
    applyStimulus(1'b1, 8'h12, 1'b1);
    checkBeat("t1_b2", 2, 8'h12);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t1_empty_valid", valid_o, 0);
    checkOutput("t1_empty_level", level_o, 0);
    checkOutput("t1_idle_eol", eol_o, 0);
    beats = 3;

    // Fill to 16 with ready low, then overflow with a 17th pixel
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
      checkOutput("t2_level", level_o, i + 1);
      checkOutput("t2_af", almost_full_o, (i + 1 >= AF_LEVEL));
    end
    checkOutput("t2_ovf_before", overflow_o, 0);
    applyStimulus(1'b1, 8'h30, 1'b0);
    checkOutput("t2_level_full", level_o, 16);
    checkOutput("t2_ovf", overflow_o, 1);
    for (int i = 0; i < 16; i++) begin
      checkBeat("t2_drain", beats, 8'(8'h20 + i));
      applyStimulus(1'b0, 8'h00, 1'b1);
      beats++;
    end
    checkOutput("t2_drained_valid", valid_o, 0);
    checkOutput("t2_drained_level", level_o, 0);
    checkOutput("t2_ovf_sticky", overflow_o, 1);

    // Simultaneous read and write at full
    srst_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    srst_i = 1'b0;
    checkOutput("t3_rst_ovf", overflow_o, 0);
    beats = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    checkOutput("t3_full", level_o, 16);
    checkBeat("t3_head", 0, 8'h40);
    applyStimulus(1'b1, 8'h50, 1'b1);
    beats = 1;
    checkOutput("t3_level_rw", level_o, 16);
    checkOutput("t3_ovf_rw", overflow_o, 0);
    for (int i = 0; i < 16; i++) begin
      checkBeat("t3_drain", beats, (i < 15) ? 8'(8'h41 + i) : 8'h50);
      applyStimulus(1'b0, 8'h00, 1'b1);
      beats++;
    end
    checkOutput("t3_drained", valid_o, 0);

    // Frame markers across a full 4x2 frame plus one beat, random ready
    srst_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    srst_i = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 9; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      checkBeat("t4_frame", got, 8'(8'h60 + got));
      applyStimulus(1'b0, 8'h00, rdy);
      if (rdy) got++;
    end
    checkOutput("t4_beats", got, 9);
    checkOutput("t4_empty", valid_o, 0);
    beats = 9;

    // Backpressure hold on an end-of-line beat
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
    checkBeat("t5_b9", 9, 8'h70);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("t5_b10", 10, 8'h71);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkBeat("t5_hold", 11, 8'h72);
      checkOutput("t5_hold_level", level_o, 4);
    end

    // Reset in mid-stream with level 6 and col 2
    srst_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    srst_i = 1'b0;
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t6_level", level_o, 6);
    checkOutput("t6_ovf", overflow_o, 1);
    checkBeat("t6_col2", 10, 8'h8A);
    srst_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    srst_i = 1'b0;
    checkOutput("t6_rst_valid", valid_o, 0);
    checkOutput("t6_rst_level", level_o, 0);
    checkOutput("t6_rst_ovf", overflow_o, 0);
    checkOutput("t6_rst_data", data_o, 0);
    applyStimulus(1'b1, 8'h99, 1'b1);
    checkBeat("t6_first", 0, 8'h99);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t6_final_valid", valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
